noc_xy_port_arbiter: RTL and testbench
======================================

// Module: noc_xy_port_arbiter
// PURPOSE
//  Output-port scheduler for one bufferless XY NoC switch (inputs left/bottom/PE, outputs right/top/PE).
//  XY-decodes the destination of each input flit and runs one 3-way round-robin arbiter per output.
//  Grants exactly one contender per free output per cycle; losers are back-pressured via o_ready_*.
//  Registers the winning flit into a holding output stage, which stalls on downstream i_ready_*.
// PARAMETERS
//  x_coord      0    this switch X coordinate
//  y_coord      0    this switch Y coordinate
//  x_size       2    bits per X coordinate field
//  y_size       2    bits per Y coordinate field
//  data_width   8    payload bits
//  total_width  2*x_size+2*y_size+data_width   flit width
//  cnt_width    16   per-output forwarded-flit counter width
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            synchronous reset, active-high
//  i_valid_l/b/pe in 1            input flit valid (left, bottom, PE)
//  i_data_l/b/pe  in total_width  input flit; dest y=[y_size-1:0], dest x=[x_size+y_size-1:y_size]
//  o_ready_l/b/pe out 1           input flit accepted this cycle (combinational)
//  o_valid_r/t/pe out 1           output flit valid (right, top, PE), registered
//  o_data_r/t/pe  out total_width output flit, registered
//  i_ready_r/t/pe in 1            downstream accepts the output flit this cycle
//  o_cnt_r/t/pe   out cnt_width   flits accepted downstream per output, wrapping
// BEHAVIOUR
//  Reset: o_valid_*=0, o_data_*=0, o_cnt_*=0, all RR pointers=LEFT, o_ready_* forced to 0 while rst=1.
//  Route (per input): dest_x!=x_coord -> RIGHT; dest_x==x_coord & dest_y!=y_coord -> TOP; else -> PE.
//   A PE flit addressed to this switch loops back to the PE output.
//  Request: req[in][out] = i_valid_in & route(in)==out. Each input requests exactly one output.
//  Free: out_free = ~o_valid_out | i_ready_out (the current flit leaves at this edge).
//  Grant: if out_free, RR-pick one requester of that output, search order from ptr_out:
//   L->B->PE->L. No grant when ~out_free.
//  o_ready_in = grant for in (at most one output can grant it). o_ready depends on i_valid.
//   Upstream must hold flit/valid until o_ready=1; valid must never depend on ready.
//  Output register on grant: o_data_out<=winner data, o_valid_out<=1. Latency: 1 clk.
//  If out_free and no grant: o_valid_out<=0, o_data_out holds. If ~out_free: hold data and valid.
//  Full throughput: a new flit on an output every cycle while downstream ready is held high.
//  Pointer: on grant, ptr_out <= winner+1 mod 3; unchanged otherwise. Pointers are independent.
//   Starvation-free: a held requester wins within 3 grants of its output.
//  Counter: o_cnt_out += 1 on (o_valid_out & i_ready_out); wraps 2^cnt_width-1 -> 0.
//  Simultaneous events: drain + new grant at the same edge is a normal replace, with no bubble.
//   Contenders for different outputs are all granted in the same cycle.
//  Reset mid-operation: held output flits are discarded (valid->0). No grants while rst=1.
//   First grant is possible in the first cycle after rst deasserts.
// STRUCTURE
//  noc_pkg: port index constants (P_L=0,P_B=1,P_PE=2; O_R,O_T,O_PE), flit field offset/width functions.
//  Sub-module rr_arb3: 3-bit req, 2-bit pointer reg, en -> one-hot gnt; ptr advances when en & |req.
//   Three instances, one per output. Route decode, output regs and counters are in the top module.
// TESTING (x_coord=1,y_coord=1,x_size=y_size=2,data_width=8)
//  Single hop: i_data_l=16'h0A59 (dest 2,1) valid, i_ready_r=1 -> o_ready_l=1. Next clk o_data_r=16'h0A59,
//   o_valid_r=1, then o_cnt_r=1.
//  Route all: L=16'h0019 (->R), B=16'h0027 (->T, dest 1,3), PE=16'h0035 (->PE) together
//   -> all three o_ready=1, each lands on its own output after 1 clk.
//  Contention: L,B,PE all dest 2,1 held valid, i_ready_r=1 -> grants L,B,PE,L... one per cycle.
//   o_ready high on exactly one input per cycle.
//  Stall: o_valid_t=1, i_ready_t=0 for 5 clks with B->TOP pending -> o_data_t stable, o_ready_b=0.
//   i_ready_t=1 -> same-edge replace, with no bubble.
//  Counter wrap: cnt_width=4, 17 flits accepted on PE output -> o_cnt_pe=1.
//  Reset mid-stream: rst=1 while o_valid_r=1 -> next clk o_valid_r=0, o_cnt_*=0.
//   L pointer priority restored: the first post-reset R contention goes to L.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared constants and flit field helpers for the XY switch port scheduler.
package noc_pkg;

    localparam int N_PORTS = 3;

    // Input port indices
    localparam int P_L  = 0;
    localparam int P_B  = 1;
    localparam int P_PE = 2;

    // Output port indices
    localparam int O_R  = 0;
    localparam int O_T  = 1;
    localparam int O_PE = 2;

    function automatic int flit_width(input int xs, input int ys, input int dw);
        return 2 * xs + 2 * ys + dw;
    endfunction

    function automatic int dest_y_lsb();
        return 0;
    endfunction

    function automatic int dest_x_lsb(input int ys);
        return ys;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// 3-way round-robin arbiter: search starts at ptr, ptr moves past the winner.
module rr_arb3
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [5:0] req_dbl;
    logic [2:0] req_rot;
    logic [2:0] pick_rot;
    logic [5:0] pick_dbl;

    // Rotate so that the pointer position is bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl  = {req, req} >> ptr;
        req_rot  = req_dbl[2:0];
        pick_rot = req_rot & (~req_rot + 3'd1);
        pick_dbl = {3'b000, pick_rot} << ptr;
        gnt      = '0;
        if (en) begin
            gnt = pick_dbl[2:0] | pick_dbl[5:3];
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        unique case (1'b1)
            gnt[P_L]:  ptr_nxt = 2'(P_B);
            gnt[P_B]:  ptr_nxt = 2'(P_PE);
            gnt[P_PE]: ptr_nxt = 2'(P_L);
            default:   ptr_nxt = ptr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'(P_L);
        end else if (|gnt) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/noc_xy_port_arbiter.sv
// Output-port scheduler for a bufferless XY switch: route decode, per-output
// round-robin grant, holding output registers and forwarded-flit counters.
module noc_xy_port_arbiter
    import noc_pkg::*;
#(
    parameter int x_coord     = 0,
    parameter int y_coord     = 0,
    parameter int x_size      = 2,
    parameter int y_size      = 2,
    parameter int data_width  = 8,
    parameter int total_width = flit_width(x_size, y_size, data_width),
    parameter int cnt_width   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid_l,
    input  logic                   i_valid_b,
    input  logic                   i_valid_pe,
    input  logic [total_width-1:0] i_data_l,
    input  logic [total_width-1:0] i_data_b,
    input  logic [total_width-1:0] i_data_pe,
    output logic                   o_ready_l,
    output logic                   o_ready_b,
    output logic                   o_ready_pe,
    output logic                   o_valid_r,
    output logic                   o_valid_t,
    output logic                   o_valid_pe,
    output logic [total_width-1:0] o_data_r,
    output logic [total_width-1:0] o_data_t,
    output logic [total_width-1:0] o_data_pe,
    input  logic                   i_ready_r,
    input  logic                   i_ready_t,
    input  logic                   i_ready_pe,
    output logic [cnt_width-1:0]   o_cnt_r,
    output logic [cnt_width-1:0]   o_cnt_t,
    output logic [cnt_width-1:0]   o_cnt_pe
);

    localparam logic [x_size-1:0] X_HERE = x_size'(x_coord);
    localparam logic [y_size-1:0] Y_HERE = y_size'(y_coord);

    logic [N_PORTS-1:0]   in_valid;
    logic [total_width-1:0] in_data [N_PORTS];
    logic [N_PORTS-1:0]   out_rdy;
    logic [N_PORTS-1:0]   route_oh [N_PORTS];
    logic [N_PORTS-1:0]   req      [N_PORTS];
    logic [N_PORTS-1:0]   gnt      [N_PORTS];
    logic [N_PORTS-1:0]   out_free;
    logic [N_PORTS-1:0]   arb_en;
    logic [total_width-1:0] win_data [N_PORTS];

    logic [N_PORTS-1:0]   valid_q;
    logic [total_width-1:0] data_q [N_PORTS];
    logic [cnt_width-1:0] cnt_q  [N_PORTS];

    assign in_valid     = {i_valid_pe, i_valid_b, i_valid_l};
    assign in_data[P_L] = i_data_l;
    assign in_data[P_B] = i_data_b;
    assign in_data[P_PE] = i_data_pe;
    assign out_rdy      = {i_ready_pe, i_ready_t, i_ready_r};

    // XY routing: correct X first, then Y, otherwise the flit is for the local PE
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            route_oh[i] = '0;
            if (in_data[i][dest_x_lsb(y_size) +: x_size] != X_HERE) begin
                route_oh[i][O_R] = 1'b1;
            end else if (in_data[i][dest_y_lsb() +: y_size] != Y_HERE) begin
                route_oh[i][O_T] = 1'b1;
            end else begin
                route_oh[i][O_PE] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            out_free[o] = ~valid_q[o] | out_rdy[o];
            arb_en[o]   = ~rst & out_free[o];
            for (int i = 0; i < N_PORTS; i++) begin
                req[o][i] = in_valid[i] & route_oh[i][o];
            end
        end
    end

    for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
        rr_arb3 u_arb (
            .clk (clk),
            .rst (rst),
            .en  (arb_en[o]),
            .req (req[o]),
            .gnt (gnt[o])
        );
    end

    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            win_data[o] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                if (gnt[o][i]) begin
                    win_data[o] = in_data[i];
                end
            end
        end
    end

    assign o_ready_l  = gnt[O_R][P_L]  | gnt[O_T][P_L]  | gnt[O_PE][P_L];
    assign o_ready_b  = gnt[O_R][P_B]  | gnt[O_T][P_B]  | gnt[O_PE][P_B];
    assign o_ready_pe = gnt[O_R][P_PE] | gnt[O_T][P_PE] | gnt[O_PE][P_PE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < N_PORTS; o++) begin
                valid_q[o] <= 1'b0;
                data_q[o]  <= '0;
                cnt_q[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                // A free output either takes the new winner or goes empty
                if (out_free[o]) begin
                    valid_q[o] <= |gnt[o];
                    if (|gnt[o]) begin
                        data_q[o] <= win_data[o];
                    end
                end
                if (valid_q[o] & out_rdy[o]) begin
                    cnt_q[o] <= cnt_q[o] + cnt_width'(1);
                end
            end
        end
    end

    assign o_valid_r  = valid_q[O_R];
    assign o_valid_t  = valid_q[O_T];
    assign o_valid_pe = valid_q[O_PE];
    assign o_data_r   = data_q[O_R];
    assign o_data_t   = data_q[O_T];
    assign o_data_pe  = data_q[O_PE];
    assign o_cnt_r    = cnt_q[O_R];
    assign o_cnt_t    = cnt_q[O_T];
    assign o_cnt_pe   = cnt_q[O_PE];

endmodule

// File: tb/tb_noc_xy_port_arbiter.sv
// Bench for noc_xy_port_arbiter at switch (1,1): directed scenarios plus random
// traffic, all checked every cycle against a behavioural scheduler model.
module tb_noc_xy_port_arbiter;

    localparam int TW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    vin = '0;
    logic [TW-1:0] din [3];
    logic [2:0]    rdy = '0;
    logic [2:0]    acc = '0;

    logic o_ready_l, o_ready_b, o_ready_pe;
    logic o_valid_r, o_valid_t, o_valid_pe;
    logic [TW-1:0] o_data_r, o_data_t, o_data_pe;
    logic [CW-1:0] o_cnt_r, o_cnt_t, o_cnt_pe;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    noc_xy_port_arbiter #(
        .x_coord(1), .y_coord(1), .x_size(2), .y_size(2),
        .data_width(8), .cnt_width(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_valid_l(vin[0]), .i_valid_b(vin[1]), .i_valid_pe(vin[2]),
        .i_data_l(din[0]), .i_data_b(din[1]), .i_data_pe(din[2]),
        .o_ready_l(o_ready_l), .o_ready_b(o_ready_b), .o_ready_pe(o_ready_pe),
        .o_valid_r(o_valid_r), .o_valid_t(o_valid_t), .o_valid_pe(o_valid_pe),
        .o_data_r(o_data_r), .o_data_t(o_data_t), .o_data_pe(o_data_pe),
        .i_ready_r(rdy[0]), .i_ready_t(rdy[1]), .i_ready_pe(rdy[2]),
        .o_cnt_r(o_cnt_r), .o_cnt_t(o_cnt_t), .o_cnt_pe(o_cnt_pe)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Destination (x,y) in the low nibble: 0=right, 1=top, 2=local PE
    function automatic int route(input logic [TW-1:0] d);
        if (d[3:2] != 2'd1) return 0;
        if (d[1:0] != 2'd1) return 1;
        return 2;
    endfunction

    // Behavioural model: what each output holds and who last won it
    bit            m_v [3];
    logic [TW-1:0] m_d [3];
    int            m_cnt [3];
    int            m_last [3];
    bit            chk_en = 0;

    always @(negedge clk) begin
        int win [3];
        bit exp_rdy [3];
        bit free;
        logic [2:0] dv;
        logic [TW-1:0] dd [3];
        logic [CW-1:0] dc [3];
        logic [2:0] dr;
        dv = {o_valid_pe, o_valid_t, o_valid_r};
        dd[0] = o_data_r; dd[1] = o_data_t; dd[2] = o_data_pe;
        dc[0] = o_cnt_r;  dc[1] = o_cnt_t;  dc[2] = o_cnt_pe;
        dr = {o_ready_pe, o_ready_b, o_ready_l};
        for (int i = 0; i < 3; i++) exp_rdy[i] = 0;
        for (int o = 0; o < 3; o++) begin
            win[o] = -1;
            free = !m_v[o] || rdy[o];
            if (free && !rst) begin
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_last[o] + k) % 3;
                    if (win[o] < 0 && vin[c] && route(din[c]) == o) win[o] = c;
                end
            end
            if (win[o] >= 0) exp_rdy[win[o]] = 1;
        end
        if (chk_en) begin
            for (int o = 0; o < 3; o++) begin
                chk($sformatf("model_valid%0d", o), 32'(dv[o]), 32'(m_v[o]));
                chk($sformatf("model_data%0d", o), 32'(dd[o]), 32'(m_d[o]));
                chk($sformatf("model_cnt%0d", o), 32'(dc[o]), 32'(m_cnt[o] % (1 << CW)));
            end
            for (int i = 0; i < 3; i++)
                chk($sformatf("model_ready%0d", i), 32'(dr[i]), 32'(exp_rdy[i]));
        end
        acc = dr;
        for (int o = 0; o < 3; o++) begin
            if (rst) begin
                m_v[o] = 0; m_d[o] = '0; m_cnt[o] = 0; m_last[o] = 2;
            end else begin
                if (m_v[o] && rdy[o]) m_cnt[o]++;
                if (win[o] >= 0) begin
                    m_v[o] = 1; m_d[o] = din[win[o]]; m_last[o] = win[o];
                end else if (!m_v[o] || rdy[o]) begin
                    m_v[o] = 0;
                end
            end
        end
        if (rst) chk_en = 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [TW-1:0] cd [3];
        cd[0] = 16'h1109; cd[1] = 16'h2209; cd[2] = 16'h3309;
        for (int i = 0; i < 3; i++) din[i] = '0;
        tick(); tick();
        chk("reset_valid_r", 32'(o_valid_r), 0);
        chk("reset_cnt_r", 32'(o_cnt_r), 0);
        chk("reset_ready_l", 32'(o_ready_l), 0);
        rst = 0;

        // Single hop left -> right
        vin[0] = 1; din[0] = 16'h0A59; rdy = 3'b111;
        #1 chk("hop_ready_l", 32'(o_ready_l), 1);
        tick(); vin = '0;
        chk("hop_valid_r", 32'(o_valid_r), 1);
        chk("hop_data_r", 32'(o_data_r), 32'h0A59);
        tick();
        chk("hop_cnt_r", 32'(o_cnt_r), 1);

        // Three inputs to three different outputs in one cycle
        vin = 3'b111; din[0] = 16'h0019; din[1] = 16'h0027; din[2] = 16'h0035;
        #1 chk("all_ready", 32'({o_ready_pe, o_ready_b, o_ready_l}), 32'h7);
        tick(); vin = '0;
        chk("all_data_r", 32'(o_data_r), 32'h0019);
        chk("all_data_t", 32'(o_data_t), 32'h0027);
        chk("all_data_pe", 32'(o_data_pe), 32'h0035);

        // Contention on right output from fresh pointers
        rst = 1; tick(); rst = 0;
        vin = 3'b111; din[0] = cd[0]; din[1] = cd[1]; din[2] = cd[2];
        for (int k = 0; k < 6; k++) begin
            #1 chk("cont_ready", 32'({o_ready_pe, o_ready_b, o_ready_l}), 32'(1 << (k % 3)));
            tick();
            chk("cont_data_r", 32'(o_data_r), 32'(cd[k % 3]));
        end
        vin = '0;

        // Stall on top output
        vin[1] = 1; din[1] = 16'h4427; rdy = 3'b111;
        tick();
        din[1] = 16'h5527; rdy[1] = 0;
        chk("stall_first", 32'(o_data_t), 32'h4427);
        for (int k = 0; k < 5; k++) begin
            #1 chk("stall_ready_b", 32'(o_ready_b), 0);
            chk("stall_hold", 32'(o_data_t), 32'h4427);
            tick();
        end
        rdy[1] = 1;
        #1 chk("unstall_ready_b", 32'(o_ready_b), 1);
        tick(); vin = '0;
        chk("replace_valid_t", 32'(o_valid_t), 1);
        chk("replace_data_t", 32'(o_data_t), 32'h5527);

        // 17 flits through PE output wrap the 4-bit counter to 1
        tick();
        vin[2] = 1; din[2] = 16'h0035; rdy = 3'b111;
        repeat (17) tick();
        vin = '0;
        tick();
        chk("wrap_cnt_pe", 32'(o_cnt_pe), 1);

        // Reset with a flit held on the right output
        vin[0] = 1; din[0] = 16'h0A59; rdy = 3'b000;
        tick(); vin = '0;
        chk("pre_rst_valid_r", 32'(o_valid_r), 1);
        rst = 1; tick();
        chk("rst_valid_r", 32'(o_valid_r), 0);
        chk("rst_cnt_pe", 32'(o_cnt_pe), 0);
        rst = 0; rdy = 3'b111;
        vin = 3'b111; din[0] = cd[0]; din[1] = cd[1]; din[2] = cd[2];
        #1 chk("post_rst_ready", 32'({o_ready_pe, o_ready_b, o_ready_l}), 32'h1);
        tick(); vin = '0;
        chk("post_rst_data_r", 32'(o_data_r), 32'h1109);

        // Random traffic obeying the hold-until-ready rule
        repeat (3000) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (!vin[i] || acc[i]) begin
                    vin[i] = ($urandom % 4) != 0;
                    din[i] = TW'($urandom);
                end
            end
            rdy = 3'($urandom);
            rst = ($urandom % 250) == 0;
        end
        rst = 0; vin = '0;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
